nanov_spi_bus_arbiter: RTL and testbench
========================================

Name: nanov_spi_bus_arbiter

Overview:
Shares the single external SPI memory bus (select, MOSI, clock enable, MISO) between the nanoV CPU and a secondary master, such as a debug or boot loader. The CPU owns the bus by default. A secondary request is granted only at a CPU transaction boundary. The CPU is then held, and on return it gets a restart pulse so it re-issues its instruction-stream read. The block sits between nanoV_cpu and the top-level SPI pins.

Parameters:
GAP_CYCLES, 4, forced-deselect cycles on each ownership change (1..255)
MAX_DBG_CYCLES, 0, max cycles the secondary may own the bus; 0 = unlimited (16-bit)

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
cpu_spi_select  input  1  CPU chip select (active low)
cpu_spi_out  input  1  CPU MOSI
cpu_spi_clk_enable  input  1  CPU SPI clock enable
cpu_spi_data_in  output  1  MISO to CPU
cpu_hold  output  1  freezes CPU (clock-enable to core) while not owner
cpu_restart  output  1  one-cycle pulse: CPU must restart instruction stream
dbg_req  input  1  secondary requests bus (level, held until done)
dbg_spi_select  input  1  secondary chip select
dbg_spi_out  input  1  secondary MOSI
dbg_spi_clk_enable  input  1  secondary SPI clock enable
dbg_gnt  output  1  secondary owns bus
dbg_spi_data_in  output  1  MISO to secondary
dbg_timeout  output  1  one-cycle pulse when grant revoked by timeout
spi_select  output  1  pin chip select
spi_out  output  1  pin MOSI
spi_clk_enable  output  1  pin clock enable
spi_data_in  input  1  pin MISO

Behaviour:
- Reset and clocking:
  - rstn is a synchronous, active-low reset; clk is the clock.
  - Reset at any time, including mid-grant, forces state CPU with gap counter 0, timeout counter 0 and lockout 0.
  - Reset values: spi_select=1, spi_out=0, spi_clk_enable=1, cpu_hold=0, cpu_restart=0, dbg_gnt=0, dbg_timeout=0.
- States (registered): CPU, DRAIN, HANDOFF, DBG, RELEASE.
- CPU state:
  - Pins are a combinational pass-through of the cpu_* inputs; cpu_spi_data_in=spi_data_in.
  - On dbg_req=1 with lockout=0, go to DRAIN.
- DRAIN:
  - CPU keeps the bus.
  - In the first cycle where cpu_spi_select=1, go to HANDOFF; the CPU is never cut mid-transaction.
  - If dbg_req falls first, return to CPU; no hold or restart is issued.
- HANDOFF:
  - cpu_hold=1.
  - Pins forced: spi_select=1, spi_out=0, spi_clk_enable=1.
  - The gap counter runs GAP_CYCLES cycles; then go to DBG.
  - If dbg_req falls during HANDOFF, go to RELEASE.
- DBG:
  - dbg_gnt=1, cpu_hold=1; pins pass through the dbg_* inputs; dbg_spi_data_in=spi_data_in.
  - The timeout counter increments each cycle.
  - On dbg_req=0, go to RELEASE.
  - If MAX_DBG_CYCLES!=0 and the counter reaches MAX_DBG_CYCLES-1 while req is still high:
    - pulse dbg_timeout in that same cycle;
    - set lockout=1;
    - go to RELEASE.
- RELEASE:
  - dbg_gnt=0, cpu_hold=1, pins forced deselected as in HANDOFF, for GAP_CYCLES cycles.
  - Then go to CPU with cpu_restart=1 for exactly that first CPU cycle; cpu_hold=0 in the same cycle.
- Lockout and MISO:
  - Lockout clears when dbg_req=0 is sampled.
  - While lockout=1, dbg_req is ignored in state CPU.
  - The non-owner's data_in is driven 0. In DRAIN, HANDOFF and RELEASE, dbg_spi_data_in=0.
- Output timing:
  - dbg_gnt, cpu_hold and cpu_restart are registered, i.e. decoded from the state register, with no combinational path from dbg_req.
  - The pin mux selects on the state register only.
- Simultaneous events:
  - The dbg_req rising edge and cpu_spi_select going high in the same cycle: CPU→DRAIN, then HANDOFF the next cycle. DRAIN is always at least one cycle.
  - A timeout and dbg_req falling in the same cycle: treat as a normal release; no dbg_timeout, no lockout.

Test Plan:
- Idle pass-through → with dbg_req=0, toggle the cpu_* inputs for 100 cycles. Pins track the CPU exactly, cpu_hold=0 and dbg_gnt=0 throughout.
- Grant at boundary → hold cpu_spi_select=0, raise dbg_req at t=10, raise cpu_spi_select at t=20.
  - DRAIN runs t=11..20, HANDOFF runs 4 cycles, dbg_gnt=1 from t=25.
  - spi_select=1 throughout t=21..24 and no dbg_* activity reaches the pins before t=25.
- Release and restart → drop dbg_req in DBG at t=40.
  - RELEASE lasts 4 cycles with spi_select=1, dbg_gnt=0 at t=41.
  - At t=45: cpu_restart=1 for one cycle and cpu_hold=0.
- Timeout → MAX_DBG_CYCLES=16, hold dbg_req high.
  - dbg_timeout pulses on the 16th DBG cycle, and the bus returns to the CPU after the gap.
  - A re-request is ignored until dbg_req has been low for at least one cycle; the next request is then granted normally.
- Abort during HANDOFF → drop dbg_req in the 2nd HANDOFF cycle. dbg_gnt is never asserted, RELEASE runs 4 cycles, then cpu_restart pulses.
- Reset mid-grant → rstn=0 for one cycle in DBG. Next cycle: state CPU, spi_select=1 (reset value), dbg_gnt=0, cpu_hold=0, lockout cleared.

Source files
------------

// File: rtl/nanov_spi_bus_arbiter.sv
// Arbitrates the external SPI memory pins between the nanoV CPU and a secondary
// master; ownership changes only at CPU transaction boundaries, with a forced-deselect gap.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   CPU      | CPU owns the pins (default)
//   DRAIN    | secondary waiting; CPU finishes its current transaction
//   HANDOFF  | CPU held, pins deselected for GAP_CYCLES
//   DBG      | secondary owns the pins
//   RELEASE  | CPU still held, pins deselected for GAP_CYCLES, then restart
module nanov_spi_bus_arbiter #(
    parameter int GAP_CYCLES     = 4,
    parameter int MAX_DBG_CYCLES = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic cpu_spi_select,
    input  logic cpu_spi_out,
    input  logic cpu_spi_clk_enable,
    output logic cpu_spi_data_in,
    output logic cpu_hold,
    output logic cpu_restart,
    input  logic dbg_req,
    input  logic dbg_spi_select,
    input  logic dbg_spi_out,
    input  logic dbg_spi_clk_enable,
    output logic dbg_gnt,
    output logic dbg_spi_data_in,
    output logic dbg_timeout,
    output logic spi_select,
    output logic spi_out,
    output logic spi_clk_enable,
    input  logic spi_data_in
);

    typedef enum logic [2:0] {
        S_CPU,
        S_DRAIN,
        S_HANDOFF,
        S_DBG,
        S_RELEASE
    } state_t;

    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam bit          TMO_EN   = (MAX_DBG_CYCLES != 0);
    localparam logic [15:0] TMO_LAST = 16'(TMO_EN ? MAX_DBG_CYCLES - 1 : 0);

    state_t      state;
    logic [7:0]  gap_cnt;
    logic [15:0] tmo_cnt;
    logic        lockout;
    logic        tmo_hit;

    // A timeout only counts while the request is still up; a simultaneous drop is a normal release.
    assign tmo_hit     = TMO_EN && (tmo_cnt == TMO_LAST) && dbg_req;
    assign dbg_timeout = (state == S_DBG) && tmo_hit;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_CPU;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            lockout     <= 1'b0;
            cpu_hold    <= 1'b0;
            cpu_restart <= 1'b0;
            dbg_gnt     <= 1'b0;
        end else begin
            cpu_restart <= 1'b0;
            if (!dbg_req)
                lockout <= 1'b0;
            case (state)
                S_CPU: begin
                    if (dbg_req && !lockout)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!dbg_req) begin
                        state <= S_CPU;
                    end else if (cpu_spi_select) begin
                        state    <= S_HANDOFF;
                        gap_cnt  <= '0;
                        cpu_hold <= 1'b1;
                    end
                end
                S_HANDOFF: begin
                    if (!dbg_req) begin
                        state   <= S_RELEASE;
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state   <= S_DBG;
                        tmo_cnt <= '0;
                        dbg_gnt <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                S_DBG: begin
                    if (!dbg_req || tmo_hit) begin
                        state   <= S_RELEASE;
                        gap_cnt <= '0;
                        dbg_gnt <= 1'b0;
                        if (tmo_hit)
                            lockout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        state       <= S_CPU;
                        cpu_hold    <= 1'b0;
                        cpu_restart <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= S_CPU;
                    cpu_hold <= 1'b0;
                    dbg_gnt  <= 1'b0;
                end
            endcase
        end
    end

    // Pin mux keyed on the state register only, so dbg_req never reaches the pins combinationally.
    always_comb begin
        spi_select      = 1'b1;
        spi_out         = 1'b0;
        spi_clk_enable  = 1'b1;
        cpu_spi_data_in = 1'b0;
        dbg_spi_data_in = 1'b0;
        case (state)
            S_CPU, S_DRAIN: begin
                spi_select      = cpu_spi_select;
                spi_out         = cpu_spi_out;
                spi_clk_enable  = cpu_spi_clk_enable;
                cpu_spi_data_in = spi_data_in;
            end
            S_DBG: begin
                spi_select      = dbg_spi_select;
                spi_out         = dbg_spi_out;
                spi_clk_enable  = dbg_spi_clk_enable;
                dbg_spi_data_in = spi_data_in;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nanov_spi_bus_arbiter.sv
// Scoreboard bench for nanov_spi_bus_arbiter: the stimulus queues the hand-planned
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_nanov_spi_bus_arbiter;

    typedef enum int {P_CPU, P_DRAIN, P_HAND, P_DBG, P_REL} phase_t;
    typedef struct {
        int         idx;
        phase_t     ph;
        logic [8:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic cpu_spi_select, cpu_spi_out, cpu_spi_clk_enable, cpu_spi_data_in;
    logic cpu_hold, cpu_restart;
    logic dbg_req, dbg_spi_select, dbg_spi_out, dbg_spi_clk_enable;
    logic dbg_gnt, dbg_spi_data_in, dbg_timeout;
    logic spi_select, spi_out, spi_clk_enable, spi_data_in;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    always #5 clk = ~clk;

    nanov_spi_bus_arbiter #(.GAP_CYCLES(4), .MAX_DBG_CYCLES(16)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .cpu_spi_select     (cpu_spi_select),
        .cpu_spi_out        (cpu_spi_out),
        .cpu_spi_clk_enable (cpu_spi_clk_enable),
        .cpu_spi_data_in    (cpu_spi_data_in),
        .cpu_hold           (cpu_hold),
        .cpu_restart        (cpu_restart),
        .dbg_req            (dbg_req),
        .dbg_spi_select     (dbg_spi_select),
        .dbg_spi_out        (dbg_spi_out),
        .dbg_spi_clk_enable (dbg_spi_clk_enable),
        .dbg_gnt            (dbg_gnt),
        .dbg_spi_data_in    (dbg_spi_data_in),
        .dbg_timeout        (dbg_timeout),
        .spi_select         (spi_select),
        .spi_out            (spi_out),
        .spi_clk_enable     (spi_clk_enable),
        .spi_data_in        (spi_data_in)
    );

    // One cycle of stimulus; ph is the hand-planned phase the arbiter should be in this cycle.
    task automatic cyc(input logic sel, input logic req, input phase_t ph,
                       input bit rs = 1'b0, input bit to = 1'b0, input logic rn = 1'b1);
        exp_t e;
        logic s, o, c, cd, dd, h, g;
        @(posedge clk);
        #1;
        rstn               = rn;
        cpu_spi_select     = sel;
        dbg_req            = req;
        cpu_spi_out        = 1'($urandom_range(0, 1));
        cpu_spi_clk_enable = 1'($urandom_range(0, 1));
        dbg_spi_select     = 1'($urandom_range(0, 1));
        dbg_spi_out        = 1'($urandom_range(0, 1));
        dbg_spi_clk_enable = 1'($urandom_range(0, 1));
        spi_data_in        = 1'($urandom_range(0, 1));
        case (ph)
            P_CPU, P_DRAIN: begin
                s = sel; o = cpu_spi_out; c = cpu_spi_clk_enable;
                cd = spi_data_in; dd = 1'b0; h = 1'b0; g = 1'b0;
            end
            P_DBG: begin
                s = dbg_spi_select; o = dbg_spi_out; c = dbg_spi_clk_enable;
                cd = 1'b0; dd = spi_data_in; h = 1'b1; g = 1'b1;
            end
            default: begin
                s = 1'b1; o = 1'b0; c = 1'b1;
                cd = 1'b0; dd = 1'b0; h = 1'b1; g = 1'b0;
            end
        endcase
        e.idx = cyc_n;
        e.ph  = ph;
        e.v   = {s, o, c, cd, dd, h, rs, g, to};
        sb.push_back(e);
        cyc_n++;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                got = {spi_select, spi_out, spi_clk_enable, cpu_spi_data_in, dbg_spi_data_in,
                       cpu_hold, cpu_restart, dbg_gnt, dbg_timeout};
                checks++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL %s cycle=%0d got=%b want=%b (sel,out,clken,cpu_din,dbg_din,hold,restart,gnt,tmo)",
                             e.ph.name(), e.idx, got, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rstn = 1'b0; cpu_spi_select = 1'b1; cpu_spi_out = 1'b0; cpu_spi_clk_enable = 1'b1;
        dbg_req = 1'b0; dbg_spi_select = 1'b1; dbg_spi_out = 1'b0; dbg_spi_clk_enable = 1'b1;
        spi_data_in = 1'b0;
        repeat (3) @(posedge clk);

        // reset state, then idle pass-through
        cyc(1, 0, P_CPU);
        repeat (100) cyc(1'($urandom_range(0, 1)), 0, P_CPU);

        // grant at boundary (t=10 req, t=20 select), release at t=40 coinciding with count 15
        repeat (10) cyc(0, 0, P_CPU);
        cyc(0, 1, P_CPU);
        repeat (9) cyc(0, 1, P_DRAIN);
        cyc(1, 1, P_DRAIN);
        repeat (4) cyc(1, 1, P_HAND);
        repeat (15) cyc(1, 1, P_DBG);
        cyc(1, 0, P_DBG);
        repeat (4) cyc(1, 0, P_REL);
        cyc(1, 0, P_CPU, 1);
        cyc(1, 0, P_CPU);

        // timeout with simultaneous req/select, lockout, then normal re-grant
        cyc(1, 1, P_CPU);
        cyc(1, 1, P_DRAIN);
        repeat (4) cyc(1, 1, P_HAND);
        repeat (15) cyc(1, 1, P_DBG);
        cyc(1, 1, P_DBG, 0, 1);
        repeat (4) cyc(1, 1, P_REL);
        cyc(1, 1, P_CPU, 1);
        repeat (4) cyc(1, 1, P_CPU);
        cyc(1, 0, P_CPU);
        cyc(1, 1, P_CPU);
        cyc(1, 1, P_DRAIN);
        repeat (4) cyc(1, 1, P_HAND);
        cyc(1, 0, P_DBG);
        repeat (4) cyc(1, 0, P_REL);
        cyc(1, 0, P_CPU, 1);
        cyc(1, 0, P_CPU);

        // abort in 2nd handoff cycle
        cyc(1, 1, P_CPU);
        cyc(1, 1, P_DRAIN);
        cyc(1, 1, P_HAND);
        cyc(1, 0, P_HAND);
        repeat (4) cyc(1, 0, P_REL);
        cyc(1, 0, P_CPU, 1);
        cyc(1, 0, P_CPU);

        // request withdrawn during drain: no hold, no restart
        cyc(0, 1, P_CPU);
        cyc(0, 1, P_DRAIN);
        cyc(0, 0, P_DRAIN);
        cyc(0, 0, P_CPU);
        cyc(1, 0, P_CPU);

        // reset mid-grant
        cyc(1, 1, P_CPU);
        cyc(1, 1, P_DRAIN);
        repeat (4) cyc(1, 1, P_HAND);
        cyc(1, 1, P_DBG);
        cyc(1, 1, P_DBG, 0, 0, 0);
        cyc(1, 1, P_CPU);
        cyc(1, 0, P_DRAIN);
        cyc(1, 0, P_CPU);

        // reset during post-timeout release clears lockout
        cyc(1, 1, P_CPU);
        cyc(1, 1, P_DRAIN);
        repeat (4) cyc(1, 1, P_HAND);
        repeat (15) cyc(1, 1, P_DBG);
        cyc(1, 1, P_DBG, 0, 1);
        cyc(1, 1, P_REL, 0, 0, 0);
        cyc(1, 1, P_CPU);
        cyc(1, 0, P_DRAIN);
        cyc(1, 0, P_CPU);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
